// File: rtl/motor_pkg.sv
// Shared definitions for the motor ramp controller: FSM states, duty width default
// and direction encoding.
package motor_pkg;

  localparam int DEF_DC_PRECISION = 8;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_BWD = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DECEL = 2'd2,
    DEAD  = 2'd3
  } state_t;

endpackage

// File: rtl/motor_tick_gen.sv
// Ramp-tick prescaler: counts 0..TICK_DIV-1 and pulses tick for one clk at the
// top of the count. clr restarts the count at 0.
module motor_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clr)    cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                 cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Duty/direction sequencer for the PWM block: slew-limited ramps, dead time on
// reversal, estop. Optional command watchdog under `define MOTOR_RAMP_WATCHDOG_EN.
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int DC_PRECISION = DEF_DC_PRECISION,
  parameter int TICK_DIV     = 100000,
  parameter int STEP         = 1,
  parameter int DEAD_TICKS   = 50,
  parameter int WDOG_TICKS   = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DC_PRECISION-1:0] cmd_duty,
  input  logic                    cmd_dir,
  input  logic                    estop,
  output logic [DC_PRECISION-1:0] duty_out,
  output logic                    dir_out,
  output logic                    busy,
  output logic                    at_target,
  output logic                    wdog_trip
);

  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);
  localparam logic [DC_PRECISION:0] STEP_W = (DC_PRECISION + 1)'(STEP);

  typedef logic [DC_PRECISION-1:0] duty_t;

  state_t        state_q, state_d;
  duty_t         duty_q, duty_d, tgt_duty_q, tgt_duty_d;
  logic          dir_q, dir_d, tgt_dir_q, tgt_dir_d;
  logic [DW-1:0] dead_q, dead_d;
  logic          tick, accept;

`ifdef MOTOR_RAMP_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_TICKS + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_TICKS - 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          trip_q, trip_d;
`endif

  motor_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (estop),
    .tick  (tick)
  );

  assign cmd_ready = !estop;
  assign accept    = cmd_valid && cmd_ready;

  // Move cur one STEP toward tgt; a remaining gap of STEP or less lands exactly.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
    logic [DC_PRECISION:0] diff;
    if (cur < tgt) begin
      diff        = {1'b0, tgt} - {1'b0, cur};
      step_toward = (diff <= STEP_W) ? tgt : cur + STEP_W[DC_PRECISION-1:0];
    end else begin
      diff        = {1'b0, cur} - {1'b0, tgt};
      step_toward = (diff <= STEP_W) ? tgt : cur - STEP_W[DC_PRECISION-1:0];
    end
  endfunction

  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    tgt_duty_d = tgt_duty_q;
    tgt_dir_d  = tgt_dir_q;
    dead_d     = dead_q;

    if (accept) begin
      tgt_duty_d = cmd_duty;
      tgt_dir_d  = cmd_dir;
    end

    unique case (state_q)
      IDLE: begin
        duty_d = '0;
        if (accept && cmd_duty != '0) begin
          dir_d   = cmd_dir;
          state_d = RUN;
        end
      end
      RUN: if (tick) begin
        if (tgt_dir_q != dir_q) begin
          duty_d  = step_toward(duty_q, '0);
          dead_d  = '0;
          state_d = (duty_d == '0) ? DEAD : DECEL;
        end else if (duty_q == '0 && tgt_duty_q == '0) begin
          dead_d  = '0;
          state_d = DEAD;
        end else begin
          duty_d = step_toward(duty_q, tgt_duty_q);
        end
      end
      DECEL: begin
        // A reversal that is cancelled resumes ramping without waiting for a tick.
        if (tgt_dir_q == dir_q) begin
          state_d = RUN;
        end else if (tick) begin
          duty_d = step_toward(duty_q, '0);
          if (duty_d == '0) begin
            dead_d  = '0;
            state_d = DEAD;
          end
        end
      end
      DEAD: begin
        duty_d = '0;
        if (tick) begin
          if (dead_q == DEAD_LAST) begin
            dead_d  = '0;
            dir_d   = tgt_dir_q;
            state_d = (tgt_duty_q != '0) ? RUN : IDLE;
          end else begin
            dead_d = dead_q + DW'(1);
          end
        end
      end
    endcase

`ifdef MOTOR_RAMP_WATCHDOG_EN
    wdog_d = wdog_q;
    trip_d = trip_q;
    if (accept) begin
      wdog_d = '0;
      trip_d = 1'b0;
    end else if (tick) begin
      if (wdog_q == WDOG_LAST) begin
        wdog_d     = '0;
        trip_d     = 1'b1;
        tgt_duty_d = '0;
      end else begin
        wdog_d = wdog_q + WW'(1);
      end
    end
`endif

    if (estop) begin
      state_d    = DEAD;
      duty_d     = '0;
      dir_d      = dir_q;
      tgt_duty_d = '0;
      dead_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      dir_q      <= DIR_FWD;
      tgt_duty_q <= '0;
      tgt_dir_q  <= DIR_FWD;
      dead_q     <= '0;
`ifdef MOTOR_RAMP_WATCHDOG_EN
      wdog_q     <= '0;
      trip_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      tgt_duty_q <= tgt_duty_d;
      tgt_dir_q  <= tgt_dir_d;
      dead_q     <= dead_d;
`ifdef MOTOR_RAMP_WATCHDOG_EN
      wdog_q     <= wdog_d;
      trip_q     <= trip_d;
`endif
    end
  end

  assign duty_out  = duty_q;
  assign dir_out   = dir_q;
  assign at_target = (state_q == IDLE || state_q == RUN) &&
                     (duty_q == tgt_duty_q) && (dir_q == tgt_dir_q);
  assign busy      = !at_target;

`ifdef MOTOR_RAMP_WATCHDOG_EN
  assign wdog_trip = trip_q;
`else
  assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with TICK_DIV=4, STEP=8, DEAD_TICKS=3, WDOG_TICKS=20.
// The watchdog section runs when MOTOR_RAMP_WATCHDOG_EN is defined.
module tb_motor_ramp_ctrl;
  import motor_pkg::*;

  localparam int TDIV = 4;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_dir, estop;
  logic       cmd_ready, dir_out, busy, at_target, wdog_trip;
  logic [7:0] cmd_duty, duty_out;

  int total = 0;
  int bad   = 0;
  int pcnt  = 0;

  always #5 clk = ~clk;

  motor_ramp_ctrl #(
    .DC_PRECISION (8),
    .TICK_DIV     (TDIV),
    .STEP         (8),
    .DEAD_TICKS   (3),
    .WDOG_TICKS   (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_duty  (cmd_duty),
    .cmd_dir   (cmd_dir),
    .estop     (estop),
    .duty_out  (duty_out),
    .dir_out   (dir_out),
    .busy      (busy),
    .at_target (at_target),
    .wdog_trip (wdog_trip)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; the bench tracks the prescaler phase itself to know tick edges.
  task automatic clk1(output bit ticked);
    @(posedge clk);
    ticked = (pcnt == TDIV - 1);
    if (reset || estop)       pcnt = 0;
    else if (pcnt == TDIV - 1) pcnt = 0;
    else                      pcnt++;
    @(negedge clk);
  endtask

  task automatic to_tick(input string tag);
    bit t = 1'b0;
    for (int i = 0; i < 2 * TDIV && !t; i++) clk1(t);
    if (!t) begin
      total++;
      bad++;
      $error("FAIL %s: no tick within %0d clocks", tag, 2 * TDIV);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic dr);
    bit t;
    cmd_valid = 1'b1;
    cmd_duty  = d;
    cmd_dir   = dr;
    clk1(t);
    cmd_valid = 1'b0;
  endtask

  initial begin
    bit t;
    reset = 1'b1; estop = 1'b0;
    cmd_valid = 1'b1; cmd_duty = 8'd40; cmd_dir = DIR_BWD;
    @(negedge clk);
    for (int i = 0; i < 3; i++) clk1(t);
    reset = 1'b0; cmd_valid = 1'b0;

    // Reset state; the command offered during reset must not have been taken.
    check("rst_duty", duty_out, 0);
    check("rst_dir", dir_out, 1);
    check("rst_at_target", at_target, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_wdog", wdog_trip, 0);

    // 1: soft start to 40 forward.
    send(8'd40, DIR_FWD);
    check("t1_busy", busy, 1);
    for (int i = 1; i <= 5; i++) begin
      to_tick("t1");
      check("t1_duty", duty_out, 8 * i);
      check("t1_dir", dir_out, 1);
    end
    check("t1_at_target", at_target, 1);
    to_tick("t1_hold");
    check("t1_hold_duty", duty_out, 40);

    // 2: reversal to 20 backward: ramp down, dead time, flip, ramp up.
    send(8'd20, DIR_BWD);
    for (int i = 1; i <= 5; i++) begin
      to_tick("t2_down");
      check("t2_down_duty", duty_out, 40 - 8 * i);
      check("t2_down_dir", dir_out, 1);
    end
    for (int i = 1; i <= 2; i++) begin
      to_tick("t2_dead");
      check("t2_dead_duty", duty_out, 0);
      check("t2_dead_dir", dir_out, 1);
      check("t2_dead_busy", busy, 1);
    end
    to_tick("t2_flip");
    check("t2_flip_duty", duty_out, 0);
    check("t2_flip_dir", dir_out, 0);
    to_tick("t2_up"); check("t2_up_duty", duty_out, 8);
    to_tick("t2_up"); check("t2_up_duty", duty_out, 16);
    to_tick("t2_up"); check("t2_up_duty", duty_out, 20);
    check("t2_at_target", at_target, 1);

    // 3: cancel a reversal mid-deceleration.
    send(8'd40, DIR_BWD);
    to_tick("t3_pre"); check("t3_pre_duty", duty_out, 28);
    to_tick("t3_pre"); check("t3_pre_duty", duty_out, 36);
    to_tick("t3_pre"); check("t3_pre_duty", duty_out, 40);
    send(8'd0, DIR_FWD);
    for (int i = 1; i <= 3; i++) begin
      to_tick("t3_decel");
      check("t3_decel_duty", duty_out, 40 - 8 * i);
    end
    check("t3_decel_busy", busy, 1);
    send(8'd40, DIR_BWD);
    for (int i = 1; i <= 3; i++) begin
      to_tick("t3_resume");
      check("t3_resume_duty", duty_out, 16 + 8 * i);
      check("t3_resume_dir", dir_out, 0);
    end
    check("t3_at_target", at_target, 1);

    // 4: estop beats a simultaneous command and holds DEAD while high.
    estop = 1'b1; cmd_valid = 1'b1; cmd_duty = 8'd100; cmd_dir = DIR_FWD;
    #1;
    check("t4_ready", cmd_ready, 0);
    clk1(t);
    check("t4_duty", duty_out, 0);
    check("t4_busy", busy, 1);
    for (int i = 0; i < 10; i++) clk1(t);
    check("t4_hold_duty", duty_out, 0);
    check("t4_hold_dir", dir_out, 0);
    check("t4_hold_at_target", at_target, 0);
    estop = 1'b0; cmd_valid = 1'b0;
    to_tick("t4_dead"); to_tick("t4_dead");
    check("t4_dead_at_target", at_target, 0);
    to_tick("t4_idle");
    check("t4_idle_at_target", at_target, 1);
    check("t4_idle_duty", duty_out, 0);
    check("t4_idle_dir", dir_out, 0);

    // 5: full-scale ramp saturates at 255, then ramps down through DEAD to IDLE.
    send(8'd255, DIR_FWD);
    check("t5_dir", dir_out, 1);
    for (int i = 1; i <= 31; i++) begin
      to_tick("t5_up");
      check("t5_up_duty", duty_out, 8 * i);
      if (i % 10 == 0) send(8'd255, DIR_FWD);
    end
    for (int i = 0; i < 3; i++) begin
      to_tick("t5_sat");
      check("t5_sat_duty", duty_out, 255);
    end
    check("t5_at_target", at_target, 1);
    send(8'd0, DIR_FWD);
    for (int i = 1; i <= 36; i++) begin
      to_tick("t5_down");
      if (i <= 32) check("t5_down_duty", duty_out, (255 > 8 * i) ? 255 - 8 * i : 0);
      if (i == 33 || i == 35) check("t5_dead_at_target", at_target, 0);
      if (i % 10 == 0) send(8'd0, DIR_FWD);
    end
    check("t5_idle_at_target", at_target, 1);
    check("t5_idle_duty", duty_out, 0);

`ifdef MOTOR_RAMP_WATCHDOG_EN
    // 6: no commands for 20 ticks trips the watchdog and ramps the motor down.
    send(8'd40, DIR_FWD);
    for (int i = 1; i <= 19; i++) to_tick("t6_run");
    check("t6_pre_trip", wdog_trip, 0);
    check("t6_pre_duty", duty_out, 40);
    to_tick("t6_trip");
    check("t6_trip", wdog_trip, 1);
    check("t6_trip_at_target", at_target, 0);
    for (int i = 1; i <= 5; i++) begin
      to_tick("t6_down");
      check("t6_down_duty", duty_out, 40 - 8 * i);
    end
    for (int i = 1; i <= 4; i++) to_tick("t6_dead");
    check("t6_idle_at_target", at_target, 1);
    check("t6_trip_sticky", wdog_trip, 1);
    send(8'd0, DIR_FWD);
    check("t6_clear", wdog_trip, 0);
`else
    // Without the watchdog, long command silence changes nothing.
    for (int i = 0; i < 25; i++) to_tick("t6_quiet");
    check("t6_no_trip", wdog_trip, 0);
    check("t6_quiet_at_target", at_target, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
